// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, owner codes and latency counter width for mem_arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;
  localparam int LCW = 2;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin pick; on a tie the requester not granted last time wins
module rr_arb2 (
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic       last_gnt_i,
  output logic [1:0] gnt_o,
  output logic       win_o
);
  assign win_o = (req0_i & req1_i) ? ~last_gnt_i : req1_i;
  assign gnt_o = (req0_i | req1_i) ? (win_o ? 2'b10 : 2'b01) : 2'b00;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises CPU and DMA accesses onto one fixed-latency memory,
// returning a one-cycle ack and registered read data per completed access.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_adr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_adr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ack,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);
  state_t         state_q;
  logic [LCW-1:0] lat_q;
  logic           last_gnt_q;
  logic           we_q;
  logic           win;
  logic [1:0]     gnt;

  rr_arb2 u_arb (
    .req0_i    (cpu_req),
    .req1_i    (dma_req),
    .last_gnt_i(last_gnt_q),
    .gnt_o     (gnt),
    .win_o     (win)
  );

  assign busy = state_q != IDLE;

  // we_q remembers read/write for the whole access since mem_we only strobes once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      lat_q      <= '0;
      last_gnt_q <= OWN_DMA;
      we_q       <= 1'b0;
      owner      <= OWN_CPU;
      mem_adr    <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      cpu_ack    <= 1'b0;
      dma_ack    <= 1'b0;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
    end else begin
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      case (state_q)
        IDLE: if (|gnt) begin
          state_q    <= ACCESS;
          owner      <= win;
          last_gnt_q <= win;
          lat_q      <= LCW'(MEM_LAT - 1);
          mem_adr    <= win ? dma_adr : cpu_adr;
          mem_wdata  <= win ? dma_wdata : cpu_wdata;
          mem_we     <= win ? dma_we : cpu_we;
          we_q       <= win ? dma_we : cpu_we;
        end
        ACCESS: begin
          mem_we <= 1'b0;
          lat_q  <= lat_q - LCW'(1);
          if (lat_q == '0) begin
            state_q <= RESP;
            cpu_ack <= owner == OWN_CPU;
            dma_ack <= owner == OWN_DMA;
            if (!we_q && owner == OWN_CPU) cpu_rdata <= mem_rdata;
            if (!we_q && owner == OWN_DMA) dma_rdata <= mem_rdata;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a fixed-latency memory model
module tb_mem_arbiter;
  localparam int LAT = 3;

  typedef struct {
    logic        own;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_cyc;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdata;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
  logic [31:0] cpu_adr = '0, cpu_wdata = '0, dma_adr = '0, dma_wdata = '0;
  logic [31:0] cpu_rdata, dma_rdata, mem_adr, mem_wdata, mem_rdata;
  logic        cpu_ack, dma_ack, mem_we, busy, owner;

  int          cyc = 0, n_vec = 0, n_err = 0, strobes = 0, free_cyc = 0;
  logic        lg_m = 1'b1;
  logic [31:0] sh_cpu = '0, sh_dma = '0;
  exp_t        exp_q[$];
  cmd_t        cpu_cq[$], dma_cq[$];
  logic [31:0] mem[0:255], exp_mem[0:255], sr[0:3];

  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_adr(dma_adr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pat(int i);
    return (i == 16) ? 32'h8C0A0004 : {16'h8C0A, 16'(i * 4)};
  endfunction

  initial for (int i = 0; i < 256; i++) begin
    mem[i] <= pat(i);
    exp_mem[i] = pat(i);
  end

  // memory returns the word LAT cycles after the address is presented
  always @(posedge clk) begin
    sr[0] <= mem[mem_adr[9:2]];
    for (int i = 1; i < 4; i++) sr[i] <= sr[i-1];
    if (mem_we) mem[mem_adr[9:2]] <= mem_wdata;
  end
  assign mem_rdata = sr[LAT-2];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  initial forever begin
    cmd_t c;
    @(posedge clk); #1;
    if (!rst_n) cpu_req = 1'b0;
    else if (!cpu_req || cpu_ack) begin
      if (cpu_cq.size() > 0) begin
        c = cpu_cq.pop_front();
        cpu_we = c.we; cpu_adr = c.adr; cpu_wdata = c.wdata; cpu_req = 1'b1;
      end else cpu_req = 1'b0;
    end
  end

  initial forever begin
    cmd_t c;
    @(posedge clk); #1;
    if (!rst_n) dma_req = 1'b0;
    else if (!dma_req || dma_ack) begin
      if (dma_cq.size() > 0) begin
        c = dma_cq.pop_front();
        dma_we = c.we; dma_adr = c.adr; dma_wdata = c.wdata; dma_req = 1'b1;
      end else dma_req = 1'b0;
    end
  end

  task automatic send(input logic own, input logic we, input logic [31:0] adr, input logic [31:0] wdata);
    cmd_t c;
    c.we = we; c.adr = adr; c.wdata = wdata;
    if (own) dma_cq.push_back(c); else cpu_cq.push_back(c);
  endtask

  // reference: one access at a time, each taking LAT+2 cycles from its IDLE cycle
  task automatic expect_acc(input logic own, input logic we, input logic [31:0] adr, input logic [31:0] wdata, input int t_req);
    exp_t e;
    int   t;
    t = (t_req > free_cyc) ? t_req : free_cyc;
    e.own = own; e.we = we; e.adr = adr; e.wdata = wdata;
    e.ack_cyc = t + LAT + 1;
    free_cyc = t + LAT + 2;
    e.rdata = exp_mem[adr[9:2]];
    if (we) exp_mem[adr[9:2]] = wdata;
    lg_m = own;
    exp_q.push_back(e);
  endtask

  task automatic acc(input logic own, input logic we, input logic [31:0] adr, input logic [31:0] wdata);
    send(own, we, adr, wdata);
    expect_acc(own, we, adr, wdata, cyc + 1);
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() > 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() > 0) begin
      chk("timeout", 32'(exp_q.size()), 0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  always @(negedge clk) if (rst_n) begin
    exp_t e;
    if (mem_we) begin
      if (exp_q.size() == 0) chk("we_unexp", 32'(mem_we), 0);
      else begin
        chk("we_isw", 32'(mem_we), 32'(exp_q[0].we));
        chk("we_adr", mem_adr, exp_q[0].adr);
        chk("we_dat", mem_wdata, exp_q[0].wdata);
        strobes++;
      end
    end
    if (busy && exp_q.size() > 0) begin
      chk("mem_adr", mem_adr, exp_q[0].adr);
      chk("owner", 32'(owner), 32'(exp_q[0].own));
    end else if (busy) chk("busy_unexp", 32'(busy), 0);
    if (cpu_ack || dma_ack) begin
      if (exp_q.size() == 0) chk("ack_unexp", 32'(cpu_ack | dma_ack), 0);
      else begin
        e = exp_q.pop_front();
        chk("ack_cpu", 32'(cpu_ack), 32'(!e.own));
        chk("ack_dma", 32'(dma_ack), 32'(e.own));
        chk("ack_cyc", 32'(cyc), 32'(e.ack_cyc));
        chk("strobes", 32'(strobes), 32'(e.we));
        strobes = 0;
        if (!e.we && e.own) sh_dma = e.rdata;
        if (!e.we && !e.own) sh_cpu = e.rdata;
      end
    end
    chk("cpu_rdata", cpu_rdata, sh_cpu);
    chk("dma_rdata", dma_rdata, sh_dma);
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_adr"}, mem_adr, 0);
    chk({tag, "_wd"}, mem_wdata, 0);
    chk({tag, "_we"}, 32'(mem_we), 0);
    chk({tag, "_acks"}, 32'({cpu_ack, dma_ack}), 0);
    chk({tag, "_crd"}, cpu_rdata, 0);
    chk({tag, "_drd"}, dma_rdata, 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_own"}, 32'(owner), 0);
  endtask

  initial begin
    int ci, di;
    logic w;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    acc(1'b0, 1'b0, 32'h40, 32'h0);
    drain();
    acc(1'b1, 1'b1, 32'h100, 32'hDEADBEEF);
    drain();
    acc(1'b0, 1'b0, 32'h100, 32'h0);
    drain();
    acc(1'b1, 1'b0, 32'h104, 32'h0);
    drain();
    for (int k = 0; k < 3; k++) begin
      send(1'b0, 1'b0, 32'h200 + 32'(k * 4), 32'h0);
      send(1'b1, 1'b1, 32'h300 + 32'(k * 4), 32'hA0000000 + 32'(k));
    end
    ci = 0; di = 0;
    while (ci < 3 || di < 3) begin
      w = (ci < 3 && di < 3) ? !lg_m : (di < 3);
      if (w) begin
        expect_acc(1'b1, 1'b1, 32'h300 + 32'(di * 4), 32'hA0000000 + 32'(di), cyc + 1);
        di++;
      end else begin
        expect_acc(1'b0, 1'b0, 32'h200 + 32'(ci * 4), 32'h0, cyc + 1);
        ci++;
      end
    end
    drain();
    acc(1'b0, 1'b0, 32'h300, 32'h0);
    drain();
    acc(1'b0, 1'b0, 32'h8, 32'h0);
    repeat (2) @(negedge clk);
    acc(1'b1, 1'b0, 32'h10, 32'h0);
    drain();
    acc(1'b0, 1'b0, 32'h0, 32'h0);
    acc(1'b0, 1'b0, 32'h4, 32'h0);
    drain();
    send(1'b0, 1'b1, 32'h20, 32'h12345678);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("pre_rst_we", 32'(mem_we), 1);
    chk("pre_rst_adr", mem_adr, 32'h20);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid");
    exp_q.delete();
    sh_cpu = '0; sh_dma = '0; strobes = 0; lg_m = 1'b1; free_cyc = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    acc(1'b0, 1'b0, 32'h40, 32'h0);
    acc(1'b1, 1'b0, 32'h104, 32'h0);
    drain();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single unified instruction/data memory of the multicycle MIPS core between two requesters: the CPU memory port and a DMA/loader port.
- Sits between the requesters and the memory.
- Serialises accesses and inserts the memory's fixed read latency.
- Returns a one-cycle ack per completed access. The CPU controller uses it as a stall: the state register holds while a CPU request is pending without ack.

Parameters:
- AW, 32, address width
- DW, 32, data width
- MEM_LAT, 1, cycles from address issue to valid mem_rdata; legal range 1..4

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request; held with cpu_we/cpu_adr/cpu_wdata stable until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_adr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_rdata  out  DW  registered read data; valid in the cpu_ack cycle, held until the next CPU read completes
- cpu_ack  out  1  one-cycle completion pulse
- dma_req, dma_we, dma_adr, dma_wdata, dma_rdata, dma_ack: same widths and rules as the CPU set, for the DMA port
- mem_adr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_we  out  1  memory write enable
- mem_rdata  in  DW  memory read data
- busy  out  1  high while an access is in flight (states ACCESS and RESP)
- owner  out  1  0 = CPU, 1 = DMA; owner of the current or last access

Behaviour:
- Reset (reset low, asynchronous): state=IDLE; mem_adr=0, mem_wdata=0, mem_we=0; cpu_ack=dma_ack=0; cpu_rdata=dma_rdata=0; busy=0; owner=0; last_gnt=1 (DMA), so the CPU wins the first tie; lat_cnt=0. Reset asserted mid-access aborts it: no ack, and no further write strobes.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, transitions:
  - No request: stay in IDLE.
  - Any request: go to ACCESS next edge.
- IDLE, winner selection:
  - Only one request present: that requester wins.
  - Both present: the requester not equal to last_gnt wins.
- IDLE, on the transition edge:
  - Latch the winner's adr/wdata/we into mem_adr/mem_wdata/mem_we.
  - owner := winner, last_gnt := winner, lat_cnt := MEM_LAT-1.
- ACCESS:
  - mem_adr/mem_wdata held.
  - mem_we is high only in the first ACCESS cycle, then cleared, giving exactly one write strobe per write.
  - lat_cnt decrements each cycle.
  - When lat_cnt==0: go to RESP. If it is a read, capture mem_rdata into the owner's rdata register on that edge.
- RESP:
  - The owner's ack is high for exactly this cycle.
  - rdata is unchanged on writes.
  - Next state is IDLE. Requests are not sampled in RESP.
- Latency: request first seen in IDLE at cycle t gives ack at cycle t+MEM_LAT+1. Peak throughput is one access per MEM_LAT+2 cycles.
- Requester rule: deassert req in the ack cycle, or keep it high with new fields. It is then sampled as a new request in the following IDLE cycle.
- Fairness: round-robin. Under continuous dual requests, grants strictly alternate, so neither requester is starved.
- A request arriving while busy waits. The requester's fields must stay stable. The arbiter does not latch it until IDLE.
- Address and data are passed unmodified; no width conversion or alignment checking.
- owner holds its value in IDLE.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, ACCESS, RESP} (2 bits)
  - owner constants OWN_CPU=1'b0 and OWN_DMA=1'b1
  - lat_cnt width, 2 bits for MEM_LAT≤4
- Sub-module rr_arb2: combinational two-way round-robin pick from (req0, req1, last_gnt), giving a grant vector and a winner index. The last_gnt register lives in mem_arbiter.

Test Plan:
- Reset with reset=0, then release; cpu_req=1, cpu_we=0, cpu_adr=0x40, mem returns 0x8C0A0004, MEM_LAT=1 -> mem_adr=0x40 for 1 cycle; cpu_ack pulses 2 cycles after the request edge; cpu_rdata=0x8C0A0004; dma_ack stays 0.
- DMA write with dma_adr=0x100, dma_wdata=0xDEADBEEF, MEM_LAT=3 -> mem_we high for exactly 1 cycle with that address/data; dma_ack 4 cycles later; dma_rdata unchanged (0).
- cpu_req and dma_req held continuously for 6 accesses -> owner sequence CPU, DMA, CPU, DMA, CPU, DMA; each ack spaced MEM_LAT+2 cycles apart.
- dma_req arrives while a CPU read is in ACCESS -> no glitch on mem_adr; DMA is granted in the IDLE cycle after cpu_ack; DMA completes with correct data.
- reset asserted in the first ACCESS cycle of a CPU write (MEM_LAT=4) -> all outputs return to reset values immediately; no ack issued; after release, a tied request is granted to the CPU.
- Back-to-back CPU reads to 0x0 then 0x4 with req held through the ack cycle -> second access issues in the cycle after RESP; cpu_rdata updates to the second word only at the second ack.
